mem_param: RTL
==============

# mem_param

Parametrised single-port synchronous memory with a handshake interface. It replaces the fixed 128x8 memory:
- width, depth and read latency are configurable;
- byte-lane write strobes;
- a sequential clear engine instead of a one-cycle array reset;
- a real `ready` output, read-valid qualification and an out-of-range error flag.

It sits between the stimulus/driver side of the memory test environment and any block needing small local storage.

## Interface
- `DATA_W`, default 8: data width in bits. Must be a multiple of 8.
- `ADDR_W`, default 7: address width in bits.
- `DEPTH`, default 128: number of words. Must satisfy 1 <= DEPTH <= 2^ADDR_W.
- `READ_LAT`, default 1: read latency in cycles. Legal values are 1 or 2.
- `clk`, in, 1: single clock; everything is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-low (0 = reset).
- `addr`, in, ADDR_W: word address.
- `wdata`, in, DATA_W: write data.
- `wstrb`, in, DATA_W/8: byte-lane write enables. Bit k covers `wdata[8k+7:8k]`.
- `w_en`, in, 1: write request.
- `r_en`, in, 1: read request.
- `ready`, out, 1: block can accept a request this cycle.
- `rdata`, out, DATA_W: read data; holds its value between reads.
- `rvalid`, out, 1: single-cycle pulse qualifying `rdata`.
- `err`, out, 1: single-cycle pulse flagging an out-of-range access.

## Operation
- States: RESET, INIT, IDLE.
- RESET: held while `rst`=0 at a clock edge.
  - Outputs: `ready`=0, `rvalid`=0, `err`=0, `rdata`=0.
  - Clear counter = 0; read pipeline flushed.
- INIT: entered on the first edge with `rst`=1.
  - Writes 0 to word `clr_cnt` each cycle and increments `clr_cnt`.
  - After word DEPTH-1 is cleared, moves to IDLE.
  - `ready`=0 throughout. Requests presented during INIT are ignored; no error is raised.
- IDLE: `ready`=1. A request is accepted on any edge where `ready`=1 and (`w_en` | `r_en`).
- Write: for each k with `wstrb[k]`=1, `mem[addr]` byte k takes `wdata` byte k. Other bytes are unchanged. `wstrb`=0 makes the write a no-op.
- Read: captures `mem[addr]` into the read pipeline.
- Simultaneous `w_en` and `r_en` to the same address is read-first:
  - `rdata` returns the pre-write contents;
  - the write takes effect for later reads.
- Throughput: one request per cycle. Back-to-back reads produce back-to-back `rvalid` pulses.
- Out-of-range (`addr` >= DEPTH):
  - Write: memory unchanged; `err` pulses 1 cycle after acceptance.
  - Read: returns `rdata`=0 with `rvalid`=1; `err` pulses in the same cycle as that `rvalid`.
- Reset mid-operation: `rst`=0 during INIT restarts clearing from word 0 once `rst` returns to 1.
  - Reads in flight are dropped: no `rvalid`.
  - A write accepted on the edge where `rst`=0 is not performed.

## Timing
- Reset to IDLE: first edge with `rst`=1 is INIT cycle 0. `ready` rises after exactly DEPTH INIT cycles. With defaults, `ready`=1 on the 129th edge after reset release.
- Write: memory updated at the accepting edge. A read accepted on the next edge sees the new data.
- Read latency:
  - READ_LAT=1: `rdata`/`rvalid` valid on the edge after acceptance.
  - READ_LAT=2: one additional register stage, so valid 2 edges after acceptance.
- `rvalid` and `err` are registered and never asserted while `ready`=0, except for reads already in flight when INIT ends (none are possible).
- Address arithmetic: `clr_cnt` is ADDR_W+1 bits wide so it cannot wrap at DEPTH = 2^ADDR_W. The range compare is unsigned.

## Test plan
- Reset/init (defaults): hold `rst`=0 for 3 cycles, then release.
  - `ready`=0 for 128 cycles, then 1.
  - Reading addresses 0, 64 and 127 returns 0 with `rvalid` one cycle later.
- Byte strobes (DATA_W=32): write 0xAABBCCDD to address 5 with `wstrb`=4'b1111, then write 0x11223344 with `wstrb`=4'b0101.
  - Read of address 5 returns 0xAA22CC44.
- Read-first plus pipelining (READ_LAT=2): write 0x55 to address 3. Next cycle, issue `w_en`=`r_en`=1 at address 3 with `wdata`=0x77, then read address 3.
  - `rvalid` pulses on 2 consecutive cycles with `rdata`=0x55, then 0x77.
  - Both pulses arrive exactly 2 edges after their requests.
- Out-of-range (DEPTH=100, ADDR_W=7):
  - Write 0x9 to address 120: `err`=1 one cycle later.
  - Read address 120: `rdata`=0, `rvalid`=1 and `err`=1 together.
  - Address 99 is unaffected.
- Reset mid-init: drive `rst`=0 at INIT cycle 50, release 2 cycles later.
  - `ready` stays 0 for a full 128 cycles after the second release.
  - Address 127, previously written with 0xFF, reads back 0.
- Stimulus during INIT: assert `w_en` with 0x12 at address 0 during INIT.
  - No `err`.
  - After `ready`, address 0 reads back 0.

Source files
------------

// File: rtl/mem_param.sv
// Single-port synchronous memory: byte strobes, sequential clear after reset, read latency 1 or 2.
// Requests are taken when ready=1; ready stays low while the array is being cleared.
module mem_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 128,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err
);

    localparam int LANES = DATA_W / 8;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_V  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                in_range;
    logic                clearing;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;
    logic                s1_vld;
    logic                s1_oob;
    logic [DATA_W-1:0]   s1_dat;

    assign in_range = ({1'b0, addr} < DEPTH_V);
    assign ready    = (state == S_IDLE);
    assign clearing = ~ready;
    assign wr_acc   = ready & w_en;
    assign rd_acc   = ready & r_en;
    // Out-of-range reads return zero rather than whatever aliases in the array.
    assign rd_word  = in_range ? mem[addr[IW-1:0]] : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET, S_INIT: state_nxt = (clr_cnt == LAST_V) ? S_IDLE : S_INIT;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // The first edge out of reset already clears word 0, so RESET counts as INIT cycle 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_RESET;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clearing) clr_cnt <= clr_cnt + ONE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (clearing) begin
                mem[clr_cnt[IW-1:0]] <= '0;
            end else if (wr_acc && in_range) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wstrb[k]) mem[addr[IW-1:0]][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Array read happens before the same-edge write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_oob <= 1'b0;
            s1_dat <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            s1_vld <= rd_acc;
            s1_oob <= rd_acc & ~in_range;
            s1_dat <= rd_word;
            if (READ_LAT == 1) begin
                rvalid <= rd_acc;
                if (rd_acc) rdata <= rd_word;
                err    <= (rd_acc | wr_acc) & ~in_range;
            end else begin
                rvalid <= s1_vld;
                if (s1_vld) rdata <= s1_dat;
                err    <= s1_oob | (wr_acc & ~in_range);
            end
        end
    end

endmodule
